// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types, frame constants and parity helper
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;
  localparam int STREAM_W       = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through FIFO with push/full input and stb/ack output
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             stb,
  input  logic             ack
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop;
  logic             wr_en;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign pop   = stb & ack;
  assign wr_en = push & (~full | pop);
  assign full  = (count == FULL_CNT);
  assign stb   = (count != '0);
  // Head word is forced to zero while empty so the output is clean after reset.
  assign data  = stb ? mem[rd_ptr] : '0;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_stream.sv
// rtl/ps2_rx_stream.sv - PS/2 device-to-host frame receiver feeding a buffered scancode stream
module ps2_rx_stream
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic [STREAM_W-1:0] output_ps2,
  output logic                output_ps2_stb,
  input  logic                output_ps2_ack,
  output logic                frame_error,
  output logic                overflow
);

  localparam int                 TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]      TO_MAX   = TW'(TIMEOUT);
  localparam logic [2:0]         LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic                     clk_s1, clk_s2, clk_s3;
  logic                     data_s1, data_s2;
  logic                     fall;
  ps2_state_e               state;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic                     parity_bit;
  logic [TW-1:0]            to_cnt;
  logic                     timeout;
  logic                     frame_ok;
  logic                     push;
  logic                     fifo_full;

  // Two-flop synchronisers; the extra clock flop gives the previous level for edge detection.
  // Reset to 1 (idle bus level) so no spurious edge appears on release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall     = clk_s3 & ~clk_s2;
  assign timeout  = (state != ST_IDLE) && !fall && (to_cnt == TO_MAX);
  assign frame_ok = data_s2 && parity_ok(shreg, parity_bit);
  assign push     = fall && (state == ST_STOP) && frame_ok;

  // Frame FSM and inactivity timer; an edge always wins over a coincident timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      to_cnt      <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (state == ST_IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TO_MAX)    to_cnt <= to_cnt + TW'(1);

      if (timeout) begin
        state       <= ST_IDLE;
        frame_error <= 1'b1;
      end else if (fall) begin
        unique case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s2, shreg[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_bit <= data_s2;
            state      <= ST_STOP;
          end
          ST_STOP: begin
            frame_error <= !frame_ok;
            state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Flags a good byte that finds the FIFO full with no pop to make room.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else      overflow <= push & fifo_full & ~(output_ps2_stb & output_ps2_ack);
  end

  stream_fifo #(
    .WIDTH (STREAM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_data ({{(STREAM_W-PS2_DATA_BITS){1'b0}}, shreg}),
    .push      (push),
    .full      (fifo_full),
    .data      (output_ps2),
    .stb       (output_ps2_stb),
    .ack       (output_ps2_ack)
  );

endmodule

// File: tb/tb_ps2_rx_stream.sv
// tb/tb_ps2_rx_stream.sv - scoreboard bench for the PS/2 receiver stream
module tb_ps2_rx_stream;

  localparam int DEPTH = 4;
  localparam int TO    = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic        ack;
  logic [31:0] dout;
  logic        stb;
  logic        fe;
  logic        ovf;

  ps2_rx_stream #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .output_ps2     (dout),
    .output_ps2_stb (stb),
    .output_ps2_ack (ack),
    .frame_error    (fe),
    .overflow       (ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          err_seen = 0;
  int          exp_err  = 0;
  int          ovf_seen = 0;
  int          exp_ovf  = 0;
  int          n_xfer   = 0;
  int          ack_mode = 0;
  bit          fe_prev  = 1'b0;
  bit          ovf_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard comparison on the falling clk edge.
  initial begin
    forever begin
      @(negedge clk);
      if (fe) begin
        err_seen++;
        check("frame_error_width", 32'(fe_prev), 32'd0);
      end
      if (ovf) begin
        ovf_seen++;
        check("overflow_width", 32'(ovf_prev), 32'd0);
      end
      fe_prev  = fe;
      ovf_prev = ovf;
      if (stb === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", dout);
        end else begin
          check("word", dout, exp_q[0]);
          if (ack === 1'b1) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
    end
  end

  // Consumer: 0 hold low, 1 hold high, 2 mostly high random, 3 toggle.
  initial begin
    ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       ack = 1'b0;
        1:       ack = 1'b1;
        2:       ack = ($urandom_range(3) != 0);
        default: ack = ~ack;
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Device-side bit driver: data changes while clock is high, host samples on the fall.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int h;
      h = $urandom_range(3, 6);
      cyc(1);
      ps2_data = bits[i];
      cyc(h);
      ps2_clk = 1'b0;
      cyc(h);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad);
    logic p;
    p = (~^b) ^ par_flip;
    return {~stop_bad, p, b, 1'b0};
  endfunction

  // Reference model: a frame is good when start=0, stop=1 and bits 1..9 hold an odd count of ones.
  task automatic model_frame(input logic [10:0] bits);
    if (bits[0] == 1'b0 && bits[10] == 1'b1 && ($countones(bits[9:1]) % 2) == 1) begin
      if (ack_mode == 0 && exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({24'h0, bits[8:1]});
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_flags();
    check("frame_error_count", 32'(err_seen), 32'(exp_err));
    check("overflow_count", 32'(ovf_seen), 32'(exp_ovf));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_bad);
    logic [10:0] bits;
    bits = mk_frame(b, par_flip, stop_bad);
    model_frame(bits);
    send_bits(bits, 11);
    cyc(6);
    check_flags();
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    int          lat;
    int          x0;

    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    check("reset_stb", 32'(stb), 32'd0);
    check("reset_data", dout, 32'd0);
    check("reset_frame_error", 32'(fe), 32'd0);
    check("reset_overflow", 32'(ovf), 32'd0);
    rst = 1'b1;
    cyc(2);
    check("release_stb", 32'(stb), 32'd0);
    check("release_data", dout, 32'd0);

    // Single frame 0x1C with latency measured from the stop-bit falling edge.
    ack_mode = 1;
    cyc(2);
    x0   = n_xfer;
    bits = mk_frame(8'h1C, 1'b0, 1'b0);
    model_frame(bits);
    send_bits(bits, 10);
    cyc(1);
    ps2_data = 1'b1;
    cyc(4);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (stb && lat == 0) lat = k;
    end
    check("stb_latency_in_1_to_4", 32'(lat >= 1 && lat <= 4), 32'd1);
    cyc(1);
    ps2_clk = 1'b1;
    cyc(6);
    check_flags();
    check("single_frame_transfers", 32'(n_xfer - x0), 32'd1);

    // Parity error, then a good 0xF0.
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    drain();

    // Lone clock pulse with data high: bad start bit.
    exp_err++;
    send_bits(11'h7FF, 1);
    cyc(6);
    check_flags();

    // Bad stop bit.
    send_frame(8'h33, 1'b0, 1'b1);

    // Partial frame abandoned by timeout, then 0x2A.
    bits = mk_frame(8'h6B, 1'b0, 1'b0);
    send_bits(bits, 5);
    exp_err++;
    cyc(TO + 10);
    check_flags();
    send_frame(8'h2A, 1'b0, 1'b0);
    drain();

    // Overflow: five frames into a depth-4 FIFO with no consumer.
    ack_mode = 0;
    cyc(2);
    for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b0, 1'b0);
    check("full_fifo_stb", 32'(stb), 32'd1);
    @(posedge clk);
    #1;
    ack_mode = 1;
    ack      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("overflow_drain_stb", 32'(stb), 32'd1);
    end
    @(negedge clk);
    check("overflow_drain_done", 32'(stb), 32'd0);
    check("overflow_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: head word held for 50 cycles, then toggled ack drains in order.
    ack_mode = 0;
    cyc(2);
    send_frame(8'hA1, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0);
    cyc(50);
    check("hold_head_word", dout, 32'h0000_00A1);
    check("hold_stb", 32'(stb), 32'd1);
    ack_mode = 3;
    drain();

    // Randomised frames with a mostly-ready consumer and occasional corruption.
    ack_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, ($urandom_range(99) < 15), ($urandom_range(99) < 10));
    end
    ack_mode = 1;
    drain();

    // Reset in the middle of a frame with two words buffered.
    ack_mode = 0;
    cyc(2);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    bits = mk_frame(8'h66, 1'b0, 1'b0);
    send_bits(bits, 6);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_stb", 32'(stb), 32'd0);
    check("midreset_data", dout, 32'd0);
    exp_q.delete();
    cyc(3);
    rst = 1'b1;
    check("midreset_release_stb", 32'(stb), 32'd0);
    cyc(20);
    check("midreset_still_empty", 32'(stb), 32'd0);
    ack_mode = 1;
    x0 = n_xfer;
    send_frame(8'h5A, 1'b0, 1'b0);
    drain();
    check("midreset_single_transfer", 32'(n_xfer - x0), 32'd1);

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_stream.md
# ps2_rx_stream

PS/2 keyboard receiver. It deserialises device-to-host frames from the PS/2 clock/data pins and delivers each scancode byte as a 32-bit word on a data/stb/ack stream. The stream has the same handshake as every other design stream and is the producing end of the `input_ps2` channel of the user design. Frames that fail checks are discarded and flagged. Valid bytes are buffered in a small FIFO so that a slow consumer does not lose keystrokes.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: scancode words buffered; power of two, ≥2.
- `TIMEOUT`, 20000: clk cycles without a PS/2 clock falling edge before a partial frame is abandoned.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `output_ps2` out 32: bits [7:0] carry the scancode; bits [31:8] are always 0.
- `output_ps2_stb` out 1: word valid.
- `output_ps2_ack` in 1: consumer accepts the word.
- `frame_error` out 1: one-cycle pulse on a bad start, parity or stop bit, or on a timeout.
- `overflow` out 1: one-cycle pulse when a valid byte is dropped because the FIFO is full.

## Operation
- **Pin synchronisation:** `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser. A third flop on the clock path detects falling edges.
- **Bit sampling:** every bit is sampled from the synchronised data on a detected falling edge.
- **Frame format:** start=0, then D0..D7 LSB first, then odd parity, then stop=1.
- **FSM states:**
  - IDLE: on an edge with data=0 go to DATA and clear the bit count. On an edge with data=1, pulse `frame_error` and stay in IDLE.
  - DATA: shift in 8 bits; go to PARITY after bit 7.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: if stop=1 and XOR(D7..D0, parity)=1, push {24'h0, byte}. Otherwise pulse `frame_error`. Always return to IDLE.
- **Timeout:** the counter clears on every detected edge and counts in every state except IDLE. If it reaches `TIMEOUT`, go to IDLE and pulse `frame_error`.
- **FIFO:** first-word-fall-through. `output_ps2_stb` = not empty, and `output_ps2` = head word.
- **Push to a full FIFO:**
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise the new byte is dropped and `overflow` pulses. The existing contents are untouched.
- **Simultaneous push and pop when the FIFO is empty:** the pop is impossible because stb=0, so only the push takes effect.

## Timing
- **Reset values** (while `rst`=0, and immediately after release):
  - FSM in IDLE; FIFO empty.
  - `output_ps2_stb`=0, `output_ps2`=0.
  - `frame_error`=0, `overflow`=0.
  - Synchroniser flops = 1, so no edge is detected on release.
- **Reset mid-frame:** the partial frame and all FIFO contents are lost.
- **Handshake:**
  - A transfer occurs on a rising `clk` edge with stb=1 and ack=1.
  - The next head word, or stb=0, appears on the following cycle.
  - `output_ps2` is stable while stb=1 and ack=0.
  - ack while stb=0 is ignored.
- **Latency:**
  - The falling edge of the raw stop bit is detected 3 clk cycles later.
  - The push happens on the detecting edge.
  - stb rises the cycle after the push (≤4 clk cycles when the FIFO was empty).
- **Throughput:** one word per cycle when ack is held high.
- **Pulse alignment:** `frame_error` and `overflow` are registered and asserted in the cycle after the detecting edge, for exactly 1 cycle.
- **Glitches:** PS/2 clock glitches shorter than 1 clk cycle may be missed. Filtering beyond the synchroniser is not required.

## Structure
- **Package `ps2_pkg`:**
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - `PS2_DATA_BITS`=8, `PS2_FRAME_BITS`=11.
  - `STREAM_W`=32.
- **Sub-module `stream_fifo`:** parameterised width/depth FWFT FIFO with push/full and a stb/ack pop side. It is reusable by the other peripheral-side streams.
- **Top module contents:** the synchroniser, the FSM and the timeout counter.

## Test plan
- **Single frame:** send 0x1C (parity 0), with `output_ps2_ack` held 1 -> exactly one transfer, `output_ps2`=32'h0000001C, no `frame_error`.
- **Parity error:** send 0x1C with parity 1 -> no stb, one `frame_error` pulse. A following 0xF0 frame is received as 32'h000000F0.
- **Timeout:** send start plus 4 data bits, then stop clocking for `TIMEOUT`+10 cycles -> one `frame_error`, FSM in IDLE. The next full 0x2A frame is received correctly.
- **Overflow:** hold ack=0 and send 5 frames 0x01..0x05 with `FIFO_DEPTH`=4 -> one `overflow` on the 5th frame. Raising ack then yields 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then stb=0.
- **Backpressure stability:** with stb=1, ack=0 for 50 cycles -> `output_ps2` unchanged. Toggling ack every other cycle delivers all words in order.
- **Reset mid-frame:** assert `rst`=0 after 6 bits with 2 words in the FIFO -> stb=0 immediately and on release, the FIFO stays empty, and the next complete frame 0x5A is delivered alone.
